instruction_encoder: RTL and testbench

//  Builds 32-bit MIPS-subset instruction words from field-level requests and streams them,

---
 rtl/instruction_encoder.sv | 218 +++++++++++++++++++++
 tb/tb_instruction_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
//
// Purpose:
//   Builds 32-bit MIPS-subset instruction words from field-level requests and
//   streams them, with sequential word addresses, to an instruction-memory
//   write port. A DEPTH-entry FIFO decouples the request side from the memory
//   side, and each side uses a valid/ready handshake.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           synchronous clear: empties the FIFO, out_addr <= BASE_ADDR
//   in_valid/ready  request handshake (accepted when both are high)
//   in_kind         0 R, 1 ADDIU, 2 ANDI, 3 BEQ, 4 BNE, 5 LW, 6 SW, 7 J
//   in_rs/rt/rd     register fields
//   in_shamt/funct  R-type shift amount and function code
//   in_imm          16-bit immediate/offset for I-type kinds
//   in_target       26-bit jump target for J
//   out_valid/ready memory-side handshake (word taken when both are high)
//   out_addr        word address of out_instr
//   out_instr       encoded instruction at the FIFO head (0 when empty)
//   count           FIFO occupancy
//   addr_wrap       one-cycle pulse after a pop that wraps out_addr to 0
// -----------------------------------------------------------------------------
module instruction_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_kind,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [5:0]               in_funct,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     addr_wrap
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    K_R     = 3'd0,
    K_ADDIU = 3'd1,
    K_ANDI  = 3'd2,
    K_BEQ   = 3'd3,
    K_BNE   = 3'd4,
    K_LW    = 3'd5,
    K_SW    = 3'd6,
    K_J     = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Combinational encoder: fields a kind does not use are simply not selected.
  // ---------------------------------------------------------------------------
  logic [31:0] enc_instr;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    enc_instr = '0;
    case (kind_e'(in_kind))
      K_R:     enc_instr = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      K_ADDIU: enc_instr = {6'b001001, in_rs, in_rt, in_imm};
      K_ANDI:  enc_instr = {6'b001100, in_rs, in_rt, in_imm};
      K_BEQ:   enc_instr = {6'b000100, in_rs, in_rt, in_imm};
      K_BNE:   enc_instr = {6'b000101, in_rs, in_rt, in_imm};
      K_LW:    enc_instr = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:    enc_instr = {6'b101011, in_rs, in_rt, in_imm};
      K_J:     enc_instr = {6'b000010, in_target};
      default: enc_instr = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              addr_wrap_q, addr_wrap_d;
  state_e            state_q, state_d;

  logic push;
  logic pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_addr_d  = out_addr_q;
    addr_wrap_d = 1'b0;
    if (flush) begin
      // Flush wins over any handshake in the same cycle; the request
      // presented alongside it is dropped.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      out_addr_d = BASE;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        out_addr_d  = out_addr_q + ADDR_W'(1);
        addr_wrap_d = &out_addr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its _d value from before the edge, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_addr_q  <= BASE;
      addr_wrap_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_addr_q  <= out_addr_d;
      addr_wrap_q <= addr_wrap_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only visible once the
  // occupancy logic says they were written, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      fifo_mem[wr_ptr_q] <= enc_instr;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state tracks the next occupancy, so the state always agrees with
  // count_q after each edge.
  always_comb begin
    state_d = S_ACTIVE;
    if (count_d == '0) begin
      state_d = S_IDLE;
    end else if (count_d == CNT_W'(DEPTH)) begin
      state_d = S_FULL;
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      S_ACTIVE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      S_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Head word is masked to zero while empty so stale entries never show.
  assign out_instr = out_valid ? fifo_mem[rd_ptr_q] : 32'h0;
  assign out_addr  = out_addr_q;
  assign count     = count_q;
  assign addr_wrap = addr_wrap_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// -----------------------------------------------------------------------------
// tb_instruction_encoder
//
// Directed bench for instruction_encoder. Two instances share all inputs: the
// default configuration (ADDR_W=8) and a narrow-address one (ADDR_W=2) used
// to observe the address wrap.
// -----------------------------------------------------------------------------
module tb_instruction_encoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_addr;
  logic [31:0] out_instr;
  logic [2:0]  count;
  logic        addr_wrap;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [1:0]  w_out_addr;
  logic [31:0] w_out_instr;
  logic [2:0]  w_count;
  logic        w_addr_wrap;

  int checks = 0;
  int errors = 0;

  instruction_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_instr(out_instr), .count(count), .addr_wrap(addr_wrap)
  );

  instruction_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_addr(w_out_addr),
    .out_instr(w_out_instr), .count(w_count), .addr_wrap(w_addr_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input vec_t v);
    in_kind   = v.kind;
    in_rs     = v.rs;
    in_rt     = v.rt;
    in_rd     = v.rd;
    in_shamt  = v.shamt;
    in_funct  = v.funct;
    in_imm    = v.imm;
    in_target = v.target;
  endtask

  task automatic drive_j(input logic [25:0] t);
    in_kind   = 3'd7;
    in_rs     = 5'd17;
    in_rt     = 5'd9;
    in_imm    = 16'hABCD;
    in_target = t;
  endtask

  function automatic logic [31:0] jw(input logic [25:0] t);
    return {6'b000010, t};
  endfunction

  int wraps;

  initial begin
    // kind rs rt rd shamt funct imm target expected
    vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0,       32'h00221820}; // add $3,$1,$2
    vecs[1] = '{3'd1, 5'd8,  5'd9,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0,       32'h25090005}; // addiu
    vecs[2] = '{3'd5, 5'd29, 5'd8,  5'd0,  5'd0,  6'h00, 16'h0004, 26'h0,       32'h8FA80004}; // lw
    vecs[3] = '{3'd3, 5'd1,  5'd2,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h1022FFFF}; // beq, junk fields
    vecs[4] = '{3'd7, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000100, 32'h08000100}; // j, junk fields
    vecs[5] = '{3'd2, 5'd3,  5'd4,  5'd0,  5'd0,  6'h00, 16'h00FF, 26'h0,       32'h306400FF}; // andi
    vecs[6] = '{3'd4, 5'd5,  5'd6,  5'd0,  5'd0,  6'h00, 16'h0010, 26'h0,       32'h14A60010}; // bne
    vecs[7] = '{3'd6, 5'd29, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0008, 26'h0,       32'hAFBF0008}; // sw
    vecs[8] = '{3'd0, 5'd0,  5'd5,  5'd4,  5'd2,  6'h00, 16'h0000, 26'h0,       32'h00052080}; // sll $4,$5,2

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_req(vecs[0]);

    // ---------------- reset state ----------------
    #12;
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr,      32'h0);
    check("rst_out_addr",  32'(out_addr),  32'd0);
    check("rst_addr_wrap", 32'(addr_wrap), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // ---------------- table: encode, one-cycle latency, sequential addr ----------------
    for (int i = 0; i < 9; i++) begin
      drive_req(vecs[i]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_instr", i), out_instr,      vecs[i].exp);
      check($sformatf("vec%0d_addr", i),  32'(out_addr),  32'(i));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("vec%0d_count_after_pop", i), 32'(count), 32'd0);
    end

    // ---------------- fill, full back-pressure, push+pop, drain ----------------
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_j(26'h10 + 26'(k));
      in_valid = 1'b1;
      step();
    end
    check("full_count",     32'(count),     32'd4);
    check("full_in_ready",  32'(in_ready),  32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    // Fifth word held while full: must neither enter nor overwrite.
    drive_j(26'h14);
    step();
    step();
    check("full_hold_count", 32'(count), 32'd4);
    check("full_head",       out_instr,  jw(26'h10));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("pop_only_count", 32'(count), 32'd3);
    check("pop_only_head",  out_instr,  jw(26'h11));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("push_pop_count", 32'(count), 32'd3);
    for (int k = 2; k < 5; k++) begin
      check($sformatf("drain%0d_instr", k), out_instr, jw(26'h10 + 26'(k)));
      step();
    end
    out_ready = 1'b0;
    check("drain_count", 32'(count),     32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // ---------------- narrow address: wrap 3 -> 0 ----------------
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("w_flush_addr", 32'(w_out_addr),  32'd0);
    check("w_flush_wrap", 32'(w_addr_wrap), 32'd0);
    wraps = 0;
    for (int k = 0; k < 5; k++) begin
      drive_j(26'h20 + 26'(k));
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (w_addr_wrap) wraps++;
      check($sformatf("w%0d_valid", k), 32'(w_out_valid), 32'd1);
      check($sformatf("w%0d_addr", k),  32'(w_out_addr),  32'(k % 4));
      check($sformatf("w%0d_instr", k), w_out_instr,      jw(26'h20 + 26'(k)));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (w_addr_wrap) wraps++;
      check($sformatf("w%0d_wrap", k), 32'(w_addr_wrap), (k == 3) ? 32'd1 : 32'd0);
    end
    check("w_wrap_pulses", 32'(wraps),      32'd1);
    check("w_end_count",   32'(w_count),    32'd0);
    check("w_end_ready",   32'(w_in_ready), 32'd1);

    // ---------------- flush with count=3 and a request present ----------------
    for (int k = 0; k < 3; k++) begin
      drive_j(26'h30 + 26'(k));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("pre_flush_count", 32'(count), 32'd3);
    drive_j(26'h3F);
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", 32'(count),     32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_addr",  32'(out_addr),  32'd0);
    check("flush_instr", out_instr,      32'h0);
    step();
    check("flush_dropped_count", 32'(count), 32'd0);
    drive_j(26'h40);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_flush_instr", out_instr,     jw(26'h40));
    check("post_flush_addr",  32'(out_addr), 32'd0);

    // ---------------- async reset mid-stream ----------------
    drive_j(26'h41);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count),     32'd0);
    check("mid_rst_instr", out_instr,      32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready),  32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    step();
    check("post_rst_count", 32'(count),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
